// File: rtl/vga_timing_gen.sv
// VGA 640x480@60 timing source: free-running pixel/line counters, sync decode,
// and a one-pixel output stage that registers the overlay generators' colour
// together with hsync_n/vsync_n so all three stay aligned at the DAC.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter logic [5:0] BG_COLOR = 6'b000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       frame_start,
  input  logic       draw_in,
  input  logic [5:0] rgb_in,
  output logic [5:0] rgb_out,
  output logic       hsync_n,
  output logic       vsync_n
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] x_reg, x_next;
  logic [9:0] y_reg, y_next;
  logic       frame_start_reg;
  logic [5:0] rgb_reg;
  logic       hsync_n_reg;
  logic       vsync_n_reg;

  logic       hs_raw;
  logic       vs_raw;
  logic       at_frame_end;
  logic [5:0] pixel_next;

  // Next-count logic: x wraps at end of line, y steps only on that wrap.
  always_comb begin
    x_next = x_reg;
    y_next = y_reg;
    if (x_reg < H_LAST) begin
      x_next = x_reg + 10'd1;
    end else begin
      x_next = 10'd0;
      if (y_reg < V_LAST) begin
        y_next = y_reg + 10'd1;
      end else begin
        y_next = 10'd0;
      end
    end
  end

  // Decode visibility, sync windows and colour selection from current counters.
  always_comb begin
    active       = (x_reg < H_VIS) && (y_reg < V_VIS);
    hs_raw       = !((x_reg >= HS_START) && (x_reg < HS_END));
    vs_raw       = !((y_reg >= VS_START) && (y_reg < VS_END));
    // frame_start is registered from the last pixel so it is high exactly
    // while the counters sit at (0,0), and stays low straight out of reset.
    at_frame_end = (x_reg == H_LAST) && (y_reg == V_LAST);
    if (!active) begin
      pixel_next = 6'b000000;
    end else if (draw_in) begin
      pixel_next = rgb_in;
    end else begin
      pixel_next = BG_COLOR;
    end
  end

  // Counters and output stage; everything holds while ce is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg           <= 10'd0;
      y_reg           <= 10'd0;
      frame_start_reg <= 1'b0;
      rgb_reg         <= 6'b000000;
      hsync_n_reg     <= 1'b1;
      vsync_n_reg     <= 1'b1;
    end else if (ce) begin
      x_reg           <= x_next;
      y_reg           <= y_next;
      frame_start_reg <= at_frame_end;
      rgb_reg         <= pixel_next;
      hsync_n_reg     <= hs_raw;
      vsync_n_reg     <= vs_raw;
    end
  end

  assign x           = x_reg;
  assign y           = y_reg;
  assign frame_start = frame_start_reg;
  assign rgb_out     = rgb_reg;
  assign hsync_n     = hsync_n_reg;
  assign vsync_n     = vsync_n_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. The full-size instance covers line-level
// behaviour; a miniature-timing instance (15x11 total) covers whole frames and
// mid-frame reset within a short run.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b0;
  logic       draw_in = 1'b0;
  logic [5:0] rgb_in = 6'b0;

  logic [9:0] x, y;
  logic       active, frame_start, hsync_n, vsync_n;
  logic [5:0] rgb_out;

  logic [9:0] s_x, s_y;
  logic       s_active, s_frame_start, s_hsync_n, s_vsync_n;
  logic [5:0] s_rgb_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut (
    .clk(clk), .rst(rst), .ce(ce), .x(x), .y(y), .active(active),
    .frame_start(frame_start), .draw_in(draw_in), .rgb_in(rgb_in),
    .rgb_out(rgb_out), .hsync_n(hsync_n), .vsync_n(vsync_n)
  );

  // Miniature timing: H 8+2+3+2=15 (hsync x=10..12), V 6+1+2+2=11 (vsync y=7..8)
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .BG_COLOR(6'b010101)
  ) dut_s (
    .clk(clk), .rst(rst), .ce(ce), .x(s_x), .y(s_y), .active(s_active),
    .frame_start(s_frame_start), .draw_in(draw_in), .rgb_in(rgb_in),
    .rgb_out(s_rgb_out), .hsync_n(s_hsync_n), .vsync_n(s_vsync_n)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; ce = 1'b1; draw_in = 1'b1; rgb_in = 6'b111111;
    tick(); tick();
    tests++;
    if (x !== 10'd0 || y !== 10'd0) begin
      fails++; $display("FAIL reset_xy: got x=%0d y=%0d want 0 0", x, y);
    end
    tests++;
    if (rgb_out !== 6'b0 || hsync_n !== 1'b1 || vsync_n !== 1'b1 || frame_start !== 1'b0) begin
      fails++;
      $display("FAIL reset_outs: got rgb=%b hs=%b vs=%b fs=%b want 000000 1 1 0",
               rgb_out, hsync_n, vsync_n, frame_start);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (frame_start !== 1'b0 || x !== 10'd1) begin
      fails++; $display("FAIL post_reset: got fs=%b x=%0d want fs=0 x=1", frame_start, x);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_count;
    ce = 1'b1; draw_in = 1'b0;
    do_reset();
    repeat (799) tick();
    tests++;
    if (x !== 10'd799 || y !== 10'd0) begin
      fails++; $display("FAIL count_799: got x=%0d y=%0d want 799 0", x, y);
    end
    tick();
    tests++;
    if (x !== 10'd0 || y !== 10'd1) begin
      fails++; $display("FAIL count_wrap: got x=%0d y=%0d want 0 1", x, y);
    end
    $display("[TB] test_count done");
  endtask

  task automatic test_hsync;
    int lows = 0;
    int first_low = -1;
    int act_bad = 0;
    logic [5:0] rgb_first = 6'b111111;
    ce = 1'b1; draw_in = 1'b1; rgb_in = 6'b111111;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      tick();
      // outputs now describe pixel x=i of line 0, counters sit at x=i+1
      if (hsync_n === 1'b0) begin
        if (first_low < 0) begin
          first_low = i;
          rgb_first = rgb_out;
        end
        lows++;
      end
      if (active !== ((i + 1) < 640 || i == 799)) act_bad++;
    end
    tests++;
    if (lows !== 96) begin
      fails++; $display("FAIL hsync_width: got %0d low cycles want 96", lows);
    end
    tests++;
    if (first_low !== 656) begin
      fails++; $display("FAIL hsync_first: got pixel %0d want 656", first_low);
    end
    tests++;
    if (rgb_first !== 6'b000000) begin
      fails++; $display("FAIL hsync_blank: got rgb=%b want 000000", rgb_first);
    end
    tests++;
    if (act_bad !== 0) begin
      fails++; $display("FAIL active_line0: got %0d bad cycles want 0", act_bad);
    end
    $display("[TB] test_hsync done");
  endtask

  task automatic test_pixels;
    int bad = 0;
    int bad_px = -1;
    logic [5:0] exp_rgb;
    ce = 1'b1; draw_in = 1'b1; rgb_in = 6'b110110;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      tick();
      exp_rgb = (i < 640) ? 6'b110110 : 6'b000000;
      if (rgb_out !== exp_rgb) begin
        if (bad_px < 0) bad_px = i;
        bad++;
      end
    end
    tests++;
    if (bad !== 0) begin
      fails++; $display("FAIL draw_line: got %0d bad pixels (first x=%0d) want 0", bad, bad_px);
    end
    bad = 0; bad_px = -1;
    draw_in = 1'b0;
    for (int i = 0; i < 800; i++) begin
      tick();
      if (rgb_out !== 6'b000000) begin
        if (bad_px < 0) bad_px = i;
        bad++;
      end
    end
    tests++;
    if (bad !== 0) begin
      fails++; $display("FAIL bg_line: got %0d bad pixels (first x=%0d) want 0", bad, bad_px);
    end
    $display("[TB] test_pixels done");
  endtask

  task automatic test_ce;
    int hold_bad = 0;
    logic [9:0] px;
    logic [5:0] prgb;
    logic       phs;
    draw_in = 1'b1; rgb_in = 6'b110110; ce = 1'b1;
    do_reset();
    for (int i = 0; i < 1600; i++) begin
      ce = (i % 2 == 0);
      px = x; prgb = rgb_out; phs = hsync_n;
      tick();
      if (!ce && (x !== px || rgb_out !== prgb || hsync_n !== phs)) hold_bad++;
      if (i == 1597) begin
        tests++;
        if (x !== 10'd799 || y !== 10'd0) begin
          fails++; $display("FAIL ce_799: got x=%0d y=%0d want 799 0", x, y);
        end
      end
    end
    tests++;
    if (x !== 10'd0 || y !== 10'd1) begin
      fails++; $display("FAIL ce_wrap: got x=%0d y=%0d want 0 1", x, y);
    end
    tests++;
    if (hold_bad !== 0) begin
      fails++; $display("FAIL ce_hold: got %0d changes while ce=0 want 0", hold_bad);
    end
    ce = 1'b1;
    $display("[TB] test_ce done");
  endtask

  task automatic test_small_frame;
    int mx = 0, my = 0, pmx, pmy;
    int pos_bad = 0, rgb_bad = 0, hs_bad = 0, vs_bad = 0, fs_bad = 0, act_bad = 0;
    int vs_lows = 0, fs_pulses = 0, wraps = 0;
    int vs_first_x = -1, vs_first_y = -1, vs_last_x = -1, vs_last_y = -1;
    logic [5:0] exp_rgb;
    logic [9:0] prev_y;
    ce = 1'b1;
    do_reset();
    for (int i = 0; i < 165; i++) begin
      draw_in = (mx % 2 == 1);
      rgb_in = 6'b101101;
      exp_rgb = (mx < 8 && my < 6) ? ((mx % 2 == 1) ? 6'b101101 : 6'b010101) : 6'b000000;
      pmx = mx; pmy = my; prev_y = s_y;
      tick();
      mx = (pmx == 14) ? 0 : pmx + 1;
      my = (pmx == 14) ? ((pmy == 10) ? 0 : pmy + 1) : pmy;
      if (s_x !== 10'(mx) || s_y !== 10'(my)) pos_bad++;
      if (s_rgb_out !== exp_rgb) rgb_bad++;
      if (s_hsync_n !== !(pmx >= 10 && pmx <= 12)) hs_bad++;
      if (s_vsync_n !== !(pmy >= 7 && pmy <= 8)) vs_bad++;
      if (s_frame_start !== (pmx == 14 && pmy == 10)) fs_bad++;
      if (s_active !== (mx < 8 && my < 6)) act_bad++;
      if (s_vsync_n === 1'b0) begin
        if (vs_first_x < 0) begin vs_first_x = pmx; vs_first_y = pmy; end
        vs_last_x = pmx; vs_last_y = pmy;
        vs_lows++;
      end
      if (s_frame_start === 1'b1) fs_pulses++;
      if (prev_y == 10'd10 && s_y == 10'd0) wraps++;
    end
    tests++;
    if (pos_bad !== 0) begin fails++; $display("FAIL frame_xy: got %0d bad want 0", pos_bad); end
    tests++;
    if (rgb_bad !== 0) begin fails++; $display("FAIL frame_rgb: got %0d bad want 0", rgb_bad); end
    tests++;
    if (hs_bad !== 0 || vs_bad !== 0) begin
      fails++; $display("FAIL frame_sync: got hs_bad=%0d vs_bad=%0d want 0 0", hs_bad, vs_bad);
    end
    tests++;
    if (fs_bad !== 0 || act_bad !== 0) begin
      fails++; $display("FAIL frame_fs_act: got fs_bad=%0d act_bad=%0d want 0 0", fs_bad, act_bad);
    end
    tests++;
    if (vs_lows !== 30 || fs_pulses !== 1 || wraps !== 1) begin
      fails++;
      $display("FAIL frame_counts: got vs_lows=%0d fs=%0d wraps=%0d want 30 1 1",
               vs_lows, fs_pulses, wraps);
    end
    tests++;
    if (vs_first_x !== 0 || vs_first_y !== 7 || vs_last_x !== 14 || vs_last_y !== 8) begin
      fails++;
      $display("FAIL vsync_edges: got first=(%0d,%0d) last=(%0d,%0d) want (0,7) (14,8)",
               vs_first_x, vs_first_y, vs_last_x, vs_last_y);
    end
    $display("[TB] test_small_frame done");
  endtask

  task automatic test_mid_reset;
    ce = 1'b1; draw_in = 1'b1; rgb_in = 6'b111111;
    do_reset();
    repeat (131) tick();
    tests++;
    if (s_x !== 10'd11 || s_y !== 10'd8 || s_hsync_n !== 1'b0 || s_vsync_n !== 1'b0) begin
      fails++;
      $display("FAIL mid_pre: got x=%0d y=%0d hs=%b vs=%b want 11 8 0 0",
               s_x, s_y, s_hsync_n, s_vsync_n);
    end
    rst = 1'b1;
    tick();
    tests++;
    if (s_x !== 10'd0 || s_y !== 10'd0 || s_hsync_n !== 1'b1 || s_vsync_n !== 1'b1 ||
        s_rgb_out !== 6'b0 || s_frame_start !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: got x=%0d y=%0d hs=%b vs=%b rgb=%b fs=%b want 0 0 1 1 000000 0",
               s_x, s_y, s_hsync_n, s_vsync_n, s_rgb_out, s_frame_start);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (s_x !== 10'd1 || s_hsync_n !== 1'b1 || s_vsync_n !== 1'b1 || s_frame_start !== 1'b0 ||
        s_rgb_out !== 6'b111111) begin
      fails++;
      $display("FAIL mid_after: got x=%0d hs=%b vs=%b fs=%b rgb=%b want 1 1 1 0 111111",
               s_x, s_hsync_n, s_vsync_n, s_frame_start, s_rgb_out);
    end
    $display("[TB] test_mid_reset done");
  endtask

  initial begin
    test_reset();
    test_count();
    test_hsync();
    test_pixels();
    test_ce();
    test_small_frame();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
